// File: rtl/lde_pkg.sv
// Shared FSM state type, default widths and helpers for line_draw_engine.
package lde_pkg;

    localparam int XW_DEF = 9;
    localparam int YW_DEF = 8;
    localparam int CW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        FINISH
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lde_setup.sv
// Combinational Bresenham setup: folds the line into the shallow,
// left-to-right case and derives dx, dy and the minor-axis direction.
module lde_setup #(
    parameter int W = 9
) (
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         steep,
    output logic [W-1:0] start_x,
    output logic [W-1:0] start_y,
    output logic [W-1:0] end_x,
    output logic [W-1:0] dx,
    output logic [W-1:0] dy,
    output logic         y_down
);

    logic [W-1:0] adx, ady;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W-1:0] end_y;

    always_comb begin
        adx   = (x1 >= x0) ? x1 - x0 : x0 - x1;
        ady   = (y1 >= y0) ? y1 - y0 : y0 - y1;
        steep = ady > adx;

        // Major axis becomes "a", minor axis becomes "b".
        a0 = steep ? y0 : x0;
        b0 = steep ? x0 : y0;
        a1 = steep ? y1 : x1;
        b1 = steep ? x1 : y1;

        if (a0 > a1) begin
            start_x = a1;
            start_y = b1;
            end_x   = a0;
            end_y   = b0;
        end else begin
            start_x = a0;
            start_y = b0;
            end_x   = a1;
            end_y   = b1;
        end

        dx     = end_x - start_x;
        dy     = (end_y >= start_y) ? end_y - start_y : start_y - end_y;
        y_down = !(start_y < end_y);
    end

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line engine: IDLE -> SETUP -> DRAW -> FINISH, one pixel per accepted cycle.
// Optional macro LDE_PIXEL_READY_EN adds a pix_ready back-pressure input.
module line_draw_engine
    import lde_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
`ifdef LDE_PIXEL_READY_EN
    input  logic          pix_ready,
`endif
    input  logic          Go,
    input  logic [XW-1:0] X0,
    input  logic [XW-1:0] X1,
    input  logic [YW-1:0] Y0,
    input  logic [YW-1:0] Y1,
    input  logic [CW-1:0] Color,
    output logic          plot,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          busy,
    output logic          done
);

    localparam int W  = max_int(XW, YW);
    localparam int EW = W + 2;

    state_t               state;
    logic [W-1:0]         lx0, ly0, lx1, ly1;
    logic [W-1:0]         cx, cy, x_end, dx_r, dy_r;
    logic signed [EW-1:0] err;
    logic                 steep_r, y_down_r;

    logic                 s_steep, s_y_down;
    logic [W-1:0]         s_start_x, s_start_y, s_end_x, s_dx, s_dy;

    lde_setup #(.W(W)) u_setup (
        .x0      (lx0),
        .y0      (ly0),
        .x1      (lx1),
        .y1      (ly1),
        .steep   (s_steep),
        .start_x (s_start_x),
        .start_y (s_start_y),
        .end_x   (s_end_x),
        .dx      (s_dx),
        .dy      (s_dy),
        .y_down  (s_y_down)
    );

    logic accept;
`ifdef LDE_PIXEL_READY_EN
    assign accept = plot && pix_ready;
`else
    assign accept = plot;
`endif

    logic signed [EW-1:0] err_add, err_next;
    logic [W-1:0]         cx_next, cy_next;
    logic [W-1:0]         setup_px, setup_py, draw_px, draw_py;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        err_add  = err + $signed({2'b00, dy_r});
        err_next = err_add;
        cy_next  = cy;
        if (!err_add[EW-1] && (err_add != '0)) begin
            cy_next  = y_down_r ? cy - W'(1) : cy + W'(1);
            err_next = err_add - $signed({2'b00, dx_r});
        end
        cx_next = cx + W'(1);

        // Steep lines were drawn with axes swapped; swap back for the output.
        setup_px = s_steep ? s_start_y : s_start_x;
        setup_py = s_steep ? s_start_x : s_start_y;
        draw_px  = steep_r ? cy_next : cx_next;
        draw_py  = steep_r ? cx_next : cy_next;
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            // NOTE: datapath registers are reset too, so an aborted line leaves no stale state.
            state    <= IDLE;
            lx0      <= '0;
            ly0      <= '0;
            lx1      <= '0;
            ly1      <= '0;
            cx       <= '0;
            cy       <= '0;
            x_end    <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            err      <= '0;
            steep_r  <= 1'b0;
            y_down_r <= 1'b0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Go) begin
                        lx0    <= W'(X0);
                        ly0    <= W'(Y0);
                        lx1    <= W'(X1);
                        ly1    <= W'(Y1);
                        colour <= Color;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    cx       <= s_start_x;
                    cy       <= s_start_y;
                    x_end    <= s_end_x;
                    dx_r     <= s_dx;
                    dy_r     <= s_dy;
                    err      <= -$signed({2'b00, s_dx >> 1});
                    steep_r  <= s_steep;
                    y_down_r <= s_y_down;
                    x        <= setup_px[XW-1:0];
                    y        <= setup_py[YW-1:0];
                    plot     <= 1'b1;
                    state    <= DRAW;
                end
                DRAW: begin
                    if (accept) begin
                        if (cx == x_end) begin
                            plot  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            cx  <= cx_next;
                            cy  <= cy_next;
                            err <= err_next;
                            x   <= draw_px[XW-1:0];
                            y   <= draw_py[YW-1:0];
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed self-checking bench for line_draw_engine; inputs driven and outputs
// sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_line_draw_engine;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic          CLOCK_50 = 1'b0;
    logic          Reset    = 1'b1;
    logic          Go       = 1'b0;
    logic [XW-1:0] X0 = '0, X1 = '0;
    logic [YW-1:0] Y0 = '0, Y1 = '0;
    logic [CW-1:0] Color = '0;
`ifdef LDE_PIXEL_READY_EN
    logic          pix_ready = 1'b1;
`endif
    logic          plot, busy, done;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;

    int errors = 0;
    int checks = 0;

    // Observations gathered by capture(); every test compares them itself.
    int obs_x[$];
    int obs_y[$];
    int obs_c[$];
    int pix_t[$];
    int done_cnt;
    int done_t;
    int done_bad;

    line_draw_engine #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
`ifdef LDE_PIXEL_READY_EN
        .pix_ready(pix_ready),
`endif
        .Go       (Go),
        .X0       (X0),
        .X1       (X1),
        .Y0       (Y0),
        .Y1       (Y1),
        .Color    (Color),
        .plot     (plot),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .busy     (busy),
        .done     (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Presents a line and a one-cycle Go; returns on the falling edge of the SETUP cycle (t=1).
    task automatic start_line(input int x0, input int y0, input int x1, input int y1, input int c);
        @(negedge CLOCK_50);
        X0    = XW'(x0);
        Y0    = YW'(y0);
        X1    = XW'(x1);
        Y1    = YW'(y1);
        Color = CW'(c);
        Go    = 1'b1;
        @(negedge CLOCK_50);
        Go    = 1'b0;
    endtask

    // Records pixels and done pulses from t=2 on, stopping one cycle after done or at the limit.
    task automatic capture(input int limit);
        obs_x.delete();
        obs_y.delete();
        obs_c.delete();
        pix_t.delete();
        done_cnt = 0;
        done_t   = -1;
        done_bad = 0;
        for (int t = 2; t <= limit; t++) begin
            @(negedge CLOCK_50);
            if (plot === 1'b1) begin
                obs_x.push_back(int'(x));
                obs_y.push_back(int'(y));
                obs_c.push_back(int'(colour));
                pix_t.push_back(t);
                if (busy !== 1'b1) done_bad++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_t = t;
                if (plot !== 1'b0 || busy !== 1'b0) done_bad++;
            end
            if (done_cnt > 0 && t > done_t) break;
        end
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
        end
        checks++;
        if (x !== '0 || y !== '0 || colour !== '0) begin
            errors++;
            $display("FAIL reset_outputs: x=%0d y=%0d colour=%0d, want 0 0 0", x, y, colour);
        end
        Reset = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b plot=%b, want 0 0", busy, plot);
        end
    endtask

    task automatic test_horizontal();
        start_line(0, 0, 3, 0, 5);
        checks++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            errors++;
            $display("FAIL horiz_setup: busy=%b plot=%b, want 1 0", busy, plot);
        end
        capture(40);
        checks++;
        if (obs_x.size() != 4) begin
            errors++;
            $display("FAIL horiz_count: got %0d pixels, want 4", obs_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_x.size()) begin
                errors++;
                $display("FAIL horiz_pix%0d: missing, want (%0d,0)", i, i);
            end else if (obs_x[i] != i || obs_y[i] != 0 || obs_c[i] != 5 || pix_t[i] != 2 + i) begin
                errors++;
                $display("FAIL horiz_pix%0d: got (%0d,%0d) c=%0d t=%0d, want (%0d,0) c=5 t=%0d",
                         i, obs_x[i], obs_y[i], obs_c[i], pix_t[i], i, 2 + i);
            end
        end
        checks++;
        if (done_cnt != 1 || done_t != 6 || done_bad != 0) begin
            errors++;
            $display("FAIL horiz_done: count=%0d t=%0d bad=%0d, want 1 6 0", done_cnt, done_t, done_bad);
        end
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0 || x !== XW'(3) || y !== YW'(0)) begin
            errors++;
            $display("FAIL horiz_idle: busy=%b plot=%b done=%b x=%0d y=%0d, want 0 0 0 3 0",
                     busy, plot, done, x, y);
        end
    endtask

    // Steep, reversed, degenerate, negative-slope and max-coordinate lines.
    task automatic test_lines();
        int lx0[5] = '{0, 3, 5, 0, 508};
        int ly0[5] = '{0, 2, 5, 3, 255};
        int lx1[5] = '{1, 0, 5, 4, 511};
        int ly1[5] = '{3, 2, 5, 1, 254};
        int n[5]   = '{4, 4, 1, 5, 4};
        int ex[18] = '{0, 0, 1, 1,  0, 1, 2, 3,  5,  0, 1, 2, 3, 4,  508, 509, 510, 511};
        int ey[18] = '{0, 1, 2, 3,  2, 2, 2, 2,  5,  3, 3, 2, 2, 1,  255, 255, 254, 254};
        int base = 0;
        for (int l = 0; l < 5; l++) begin
            start_line(lx0[l], ly0[l], lx1[l], ly1[l], l + 1);
            capture(40);
            checks++;
            if (obs_x.size() != n[l]) begin
                errors++;
                $display("FAIL line%0d_count: got %0d pixels, want %0d", l, obs_x.size(), n[l]);
            end
            for (int i = 0; i < n[l]; i++) begin
                checks++;
                if (i >= obs_x.size()) begin
                    errors++;
                    $display("FAIL line%0d_pix%0d: missing, want (%0d,%0d)", l, i, ex[base+i], ey[base+i]);
                end else if (obs_x[i] != ex[base+i] || obs_y[i] != ey[base+i] ||
                             obs_c[i] != l + 1 || pix_t[i] != 2 + i) begin
                    errors++;
                    $display("FAIL line%0d_pix%0d: got (%0d,%0d) c=%0d t=%0d, want (%0d,%0d) c=%0d t=%0d",
                             l, i, obs_x[i], obs_y[i], obs_c[i], pix_t[i],
                             ex[base+i], ey[base+i], l + 1, 2 + i);
                end
            end
            checks++;
            if (done_cnt != 1 || done_t != 2 + n[l] || done_bad != 0) begin
                errors++;
                $display("FAIL line%0d_done: count=%0d t=%0d bad=%0d, want 1 %0d 0",
                         l, done_cnt, done_t, done_bad, 2 + n[l]);
            end
            base += n[l];
        end
    endtask

    task automatic test_reset_mid_line();
        int stray = 0;
        start_line(0, 0, 7, 0, 3);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (plot !== 1'b1 || x !== XW'(1)) begin
            errors++;
            $display("FAIL abort_second_pix: plot=%b x=%0d, want 1 1", plot, x);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x !== '0 || y !== '0 || colour !== '0) begin
            errors++;
            $display("FAIL abort_immediate: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, want all 0",
                     plot, busy, done, x, y, colour);
        end
        @(negedge CLOCK_50);
        Reset = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLOCK_50);
            if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles after reset, want 0", stray);
        end
        start_line(0, 0, 7, 0, 4);
        capture(60);
        checks++;
        if (obs_x.size() != 8 || done_cnt != 1 || done_t != 10) begin
            errors++;
            $display("FAIL abort_redraw: pixels=%0d done=%0d t=%0d, want 8 1 10", obs_x.size(), done_cnt, done_t);
        end
        for (int i = 0; i < obs_x.size(); i++) begin
            checks++;
            if (obs_x[i] != i || obs_y[i] != 0 || obs_c[i] != 4) begin
                errors++;
                $display("FAIL abort_redraw_pix%0d: got (%0d,%0d) c=%0d, want (%0d,0) c=4",
                         i, obs_x[i], obs_y[i], obs_c[i], i);
            end
        end
    endtask

    // Go held for 10 cycles: one full line, an IDLE gap, then exactly one more line.
    task automatic test_back_to_back();
        int pixels = 0;
        int dones[$];
        logic busy_t7 = 1'b1, plot_t7 = 1'b1, busy_t8 = 1'b0;
        @(negedge CLOCK_50);
        X0 = '0; Y0 = '0; X1 = XW'(3); Y1 = '0; Color = CW'(6);
        Go = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge CLOCK_50);
            if (plot === 1'b1) pixels++;
            if (done === 1'b1) dones.push_back(t);
            if (t == 7) begin busy_t7 = busy; plot_t7 = plot; end
            if (t == 8) busy_t8 = busy;
            if (t == 10) Go = 1'b0;
        end
        checks++;
        if (pixels != 8) begin
            errors++;
            $display("FAIL b2b_pixels: got %0d, want 8", pixels);
        end
        checks++;
        if (dones.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d, want 2", dones.size());
        end else if (dones[0] != 6 || dones[1] != 13) begin
            errors++;
            $display("FAIL b2b_done_times: got %0d,%0d, want 6,13", dones[0], dones[1]);
        end
        checks++;
        if (busy_t7 !== 1'b0 || plot_t7 !== 1'b0 || busy_t8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: t7 busy=%b plot=%b t8 busy=%b, want 0 0 1", busy_t7, plot_t7, busy_t8);
        end
    endtask

`ifdef LDE_PIXEL_READY_EN
    task automatic test_pix_ready();
        start_line(0, 0, 2, 0, 2);
        @(negedge CLOCK_50);
        checks++;
        if (plot !== 1'b1 || x !== XW'(0) || y !== YW'(0)) begin
            errors++;
            $display("FAIL stall_pix0: plot=%b (%0d,%0d), want 1 (0,0)", plot, x, y);
        end
        @(negedge CLOCK_50);
        pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50);
            checks++;
            if (plot !== 1'b1 || x !== XW'(1) || y !== YW'(0) || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: plot=%b (%0d,%0d) done=%b, want 1 (1,0) 0", k, plot, x, y, done);
            end
        end
        pix_ready = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if (plot !== 1'b1 || x !== XW'(2) || y !== YW'(0)) begin
            errors++;
            $display("FAIL stall_pix2: plot=%b (%0d,%0d), want 1 (2,0)", plot, x, y);
        end
        @(negedge CLOCK_50);
        checks++;
        if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b plot=%b busy=%b at t=8, want 1 0 0", done, plot, busy);
        end
        @(negedge CLOCK_50);
    endtask
`endif

    initial begin
        test_reset();
        test_horizontal();
        test_lines();
        test_reset_mid_line();
        test_back_to_back();
`ifdef LDE_PIXEL_READY_EN
        test_pix_ready();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
